// File: rtl/pattern_detect_ctrl_pkg.sv
// pattern_detect_ctrl_pkg
//   Shared definitions for the serial pattern detector: FSM state encoding,
//   default sizing and the power-on pattern/length configuration.
package pattern_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned PD_MAX_LEN = 8;
  localparam int unsigned PD_CNT_W   = 8;

  // Power-on pattern 01101 (newest bit in the LSB), length 5.
  localparam logic [4:0] DEF_PATTERN = 5'b01101;
  localparam logic [3:0] DEF_LEN     = 4'd5;

endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core
//   History shift register, fill counter and masked comparator.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     clear_i         clear history and fill (scan start)
//     shift_i         accept d_i this cycle
//     d_i             serial data bit, shifted into the history LSB
//     pattern_i       pattern to match (LSB = newest bit)
//     len_i           active pattern length
//     match_o         the bit accepted this cycle completes a match
module pattern_match_core #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               d_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [3:0]         len_i,
  output logic               match_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [3:0]         fill_q, fill_d;
  logic [3:0]         fill_inc;

  // Only the low len bits of history take part in the comparison.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_i)) mask[i] = 1'b1;
    end
  end

  assign cand     = {hist_q[MAX_LEN-2:0], d_i};
  // Fill saturates at len, so once the window is full every new bit is
  // compared against the sliding window.
  assign fill_inc = (fill_q >= len_i) ? len_i : fill_q + 4'd1;
  assign match_o  = shift_i && (fill_inc == len_i) &&
                    (((cand ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = cand;
      fill_d = match_o ? 4'd0 : fill_inc;  // non-overlapping detection
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// pattern_detect_ctrl
//   Programmable serial pattern detector with scan control.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     cfg_we          config write (pattern/len/target), only in IDLE/DONE
//     cfg_pattern     pattern bits, LSB = most recent bit
//     cfg_len         pattern length, legal 1..MAX_LEN
//     cfg_target      match count that ends a scan, 0 = unlimited
//     start, stop     arm / abort a scan (stop wins)
//     v_i, d_i        serial data valid / bit
//     pattern_detect  one-cycle match pulse
//     busy, done      state ARMED / state DONE
//     cfg_err         one-cycle pulse on a rejected config write
//     match_cnt       matches in the current or last scan (saturating)
module pattern_detect_ctrl
  import pattern_detect_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN = PD_MAX_LEN,
  parameter int unsigned CNT_W   = PD_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               v_i,
  input  logic               d_i,
  output logic               pattern_detect,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [3:0]         len_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               pd_q;
  logic               cfg_err_q;

  logic len_ok;
  logic armed;
  logic core_clear;
  logic core_shift;
  logic match;

  assign len_ok     = (cfg_len != 4'd0) && (cfg_len <= 4'(MAX_LEN));
  assign armed      = (state_q == ST_ARMED);
  assign core_clear = !armed && start;
  // stop has priority: a bit presented together with stop is dropped.
  assign core_shift = armed && !stop && v_i;
  assign cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  pattern_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst),
    .clear_i   (core_clear),
    .shift_i   (core_shift),
    .d_i       (d_i),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .match_o   (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= MAX_LEN'(DEF_PATTERN);
      len_q     <= DEF_LEN;
      target_q  <= '0;
      cnt_q     <= '0;
      pd_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pd_q      <= 1'b0;
      cfg_err_q <= 1'b0;

      if (cfg_we) begin
        if (!armed && len_ok) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
          target_q  <= cfg_target;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_ARMED;
            cnt_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (match) begin
            pd_q  <= 1'b1;
            cnt_q <= cnt_d;
            if ((target_q != '0) && (cnt_d == target_q)) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pattern_detect = pd_q;
  assign cfg_err        = cfg_err_q;
  assign match_cnt      = cnt_q;
  assign busy           = (state_q == ST_ARMED);
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
module tb_pattern_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start;
  logic       stop;
  logic       v_i;
  logic       d_i;
  logic       pattern_detect;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] match_cnt;

  pattern_detect_ctrl #(
    .MAX_LEN (8),
    .CNT_W   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_pattern    (cfg_pattern),
    .cfg_len        (cfg_len),
    .cfg_target     (cfg_target),
    .start          (start),
    .stop           (stop),
    .v_i            (v_i),
    .d_i            (d_i),
    .pattern_detect (pattern_detect),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .match_cnt      (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;

  // Reference model: scan described as a list of accepted bits.
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  int          m_state;
  int unsigned m_pattern;
  int unsigned m_len;
  int unsigned m_target;
  int unsigned m_cnt;
  int unsigned m_last_end;   // number of bits accepted when the last match ended
  bit          m_bits[$];
  bit          e_pd;
  bit          e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = M_IDLE;
    m_pattern  = 32'b01101;
    m_len      = 5;
    m_target   = 0;
    m_cnt      = 0;
    m_last_end = 0;
    m_bits.delete();
    e_pd       = 0;
    e_err      = 0;
  endtask

  task automatic model_step();
    int unsigned n;
    int unsigned val;
    e_pd  = 0;
    e_err = 0;
    if (cfg_we) begin
      if (m_state != M_ARMED && cfg_len >= 1 && cfg_len <= 8) begin
        m_pattern = cfg_pattern;
        m_len     = cfg_len;
        m_target  = cfg_target;
      end else begin
        e_err = 1;
      end
    end
    if (m_state != M_ARMED) begin
      if (start) begin
        m_state    = M_ARMED;
        m_cnt      = 0;
        m_last_end = 0;
        m_bits.delete();
      end
    end else if (stop) begin
      m_state = M_IDLE;
    end else if (v_i) begin
      m_bits.push_back(d_i);
      n = m_bits.size();
      if (n - m_last_end >= m_len) begin
        val = 0;
        for (int unsigned k = 0; k < m_len; k++)
          if (m_bits[n-1-k]) val += (1 << k);
        if (val == (m_pattern & ((1 << m_len) - 1))) begin
          e_pd       = 1;
          m_last_end = n;
          if (m_cnt != 255) m_cnt++;
          if (m_target != 0 && m_cnt == m_target) m_state = M_DONE;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("pattern_detect", pattern_detect, e_pd);
    chk("busy", busy, (m_state == M_ARMED));
    chk("done", done, (m_state == M_DONE));
    chk("cfg_err", cfg_err, e_err);
    chk("match_cnt", match_cnt, m_cnt);
  endtask

  // Inputs are set 1 time unit after a rising edge; outputs are checked
  // 1 time unit after the next rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    if (pattern_detect === 1'b1) pulses++;
    cfg_we = 0; start = 0; stop = 0; v_i = 0; d_i = 0;
  endtask

  task automatic idle_inputs();
    cfg_we = 0; start = 0; stop = 0; v_i = 0; d_i = 0;
  endtask

  task automatic do_start();
    start = 1;
    cycle();
  endtask

  task automatic do_stop();
    stop = 1;
    cycle();
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
    cfg_we = 1; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    cycle();
  endtask

  // Send the n low bits of 'bits', oldest (bit n-1) first.
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      v_i = 1; d_i = bits[i];
      cycle();
    end
  endtask

  initial begin
    rst = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    idle_inputs();
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Reset then 0,1,1,0,1 with default config: pulse on the 5th bit.
    do_start();
    pulses = 0;
    send_bits(16'b01101, 5);
    chk("req037_pulses", pulses, 1);
    chk("req037_cnt", match_cnt, 1);

    // Non-overlapping detection with default config.
    do_stop();
    do_start();
    pulses = 0;
    send_bits(16'b0110101101, 10);
    chk("req038_two", pulses, 2);
    do_stop();
    do_start();
    pulses = 0;
    send_bits(16'b01101101, 8);
    chk("req038_one", pulses, 1);

    // Short pattern with target 2: scan ends in DONE, later bits ignored.
    do_stop();
    do_cfg(8'b101, 4'd3, 8'd2);
    do_start();
    pulses = 0;
    send_bits(16'b101101, 6);
    chk("req039_pulses", pulses, 2);
    chk("req039_done", done, 1);
    send_bits(16'b101101, 6);
    chk("req039_ignored", pulses, 2);
    chk("req039_cnt", match_cnt, 2);

    // Rejected config writes: during ARMED and with len 0.
    do_start();
    do_cfg(8'hFF, 4'd8, 8'd0);
    do_stop();
    do_cfg(8'hFF, 4'd0, 8'd0);
    do_cfg(8'hFF, 4'd9, 8'd0);
    do_start();
    pulses = 0;
    send_bits(16'b101, 3);
    chk("req040_cfg_kept", pulses, 1);
    do_stop();

    // stop with start in ARMED resolves as stop; v_i gaps inside a match.
    do_cfg(8'b01101, 4'd5, 8'd0);
    do_start();
    pulses = 0;
    send_bits(16'b01, 2);
    cycle(); cycle();
    send_bits(16'b10, 2);
    cycle();
    send_bits(16'b1, 1);
    chk("req041_gap_match", pulses, 1);
    start = 1; stop = 1;
    cycle();
    chk("req041_idle", busy, 0);
    chk("req041_cnt_kept", match_cnt, 1);

    // Counter saturation: length-1 pattern matches on every 1 bit.
    do_cfg(8'b1, 4'd1, 8'd0);
    do_start();
    for (int i = 0; i < 300; i++) begin
      v_i = 1; d_i = 1;
      cycle();
    end
    chk("sat_cnt", match_cnt, 8'hFF);
    do_stop();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cfg_we      = ($urandom_range(0, 24) == 0);
      cfg_pattern = 8'($urandom);
      cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
      cfg_target  = 8'($urandom_range(0, 3));
      start       = ($urandom_range(0, 11) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      v_i         = ($urandom_range(0, 3) != 0);
      d_i         = 1'($urandom);
      cycle();
    end

    // Reset mid-pattern discards partial history.
    if (busy === 1'b1) do_stop();
    do_cfg(8'b01101, 4'd5, 8'd0);
    do_start();
    pulses = 0;
    send_bits(16'b011, 3);
    rst = 0;
    #1;
    model_reset();
    check_outputs();
    #2 rst = 1;
    send_bits(16'b01, 2);
    chk("req042_no_pulse", pulses, 0);
    chk("req042_idle", busy, 0);
    do_start();
    send_bits(16'b01, 2);
    chk("req042_restart_no_pulse", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_detect_ctrl.md
PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

Interface
REQ-001 Parameter: MAX_LEN, default 8, maximum programmable pattern length in bits.
REQ-002 Parameter: CNT_W, default 8, width of the match counter and the match target.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: cfg_we  in  1  configuration write strobe.
REQ-006 Port: cfg_pattern  in  MAX_LEN  pattern bits; LSB is the most recently received bit.
REQ-007 Port: cfg_len  in  4  pattern length, legal range 1..MAX_LEN.
REQ-008 Port: cfg_target  in  CNT_W  match count that ends a scan; 0 means unlimited.
REQ-009 Port: start  in  1  arm a scan.
REQ-010 Port: stop  in  1  abort a scan.
REQ-011 Port: v_i  in  1  serial data valid.
REQ-012 Port: d_i  in  1  serial data bit.
REQ-013 Port: pattern_detect  out  1  one-cycle match pulse.
REQ-014 Port: busy  out  1  high while in ARMED.
REQ-015 Port: done  out  1  high while in DONE.
REQ-016 Port: cfg_err  out  1  one-cycle pulse on a rejected configuration write.
REQ-017 Port: match_cnt  out  CNT_W  number of matches in the current or last scan.

Function
REQ-018 The FSM SHALL have three states: IDLE, ARMED and DONE; busy and done are decoded directly from state.
REQ-019 In IDLE or DONE, cfg_we with cfg_len in 1..MAX_LEN SHALL load pattern, len and target on that clock edge.
REQ-020 A cfg_we with an illegal cfg_len, or any cfg_we while in ARMED, SHALL leave the config unchanged and pulse cfg_err high for exactly one cycle.
REQ-021 start in IDLE or DONE SHALL move the FSM to ARMED on the next edge and clear match_cnt, the history register and the fill counter.
REQ-022 start while in ARMED SHALL be ignored.
REQ-023 stop in ARMED SHALL return the FSM to IDLE on the next edge with match_cnt retained; stop and start asserted together SHALL resolve as stop.
REQ-024 In ARMED with v_i=1, the block SHALL shift d_i into the LSB of the history register and increment fill, saturating at len.
REQ-025 In ARMED with v_i=0, history, fill and outputs SHALL hold, except that pattern_detect returns to 0.
REQ-026 A match occurs when, including the bit just accepted, fill equals len and the low len bits of history equal the low len bits of pattern.
REQ-027 On a match, pattern_detect SHALL be registered high on the same edge that accepts the final bit, for exactly one cycle.
REQ-028 On a match, fill SHALL be cleared to 0, giving non-overlapping detection, and match_cnt SHALL increment, saturating at all-ones.
REQ-029 On a mismatch with fill equal to len, fill SHALL stay at len, giving a sliding-window search.
REQ-030 If target is nonzero and the incremented match_cnt equals target, the FSM SHALL enter DONE on that same edge.
REQ-031 In DONE, v_i and d_i SHALL be ignored and match_cnt SHALL hold.
REQ-032 History bits above len SHALL NOT take part in the comparison.

Reset
REQ-033 rst low SHALL asynchronously force state IDLE, pattern 01101 (zero-extended), len 5, target 0, match_cnt 0, history 0, fill 0, and pattern_detect, cfg_err, busy and done all 0.
REQ-034 Reset asserted mid-scan SHALL discard partial history; no pattern_detect pulse is produced after reset deassertion until new bits arrive.

Structure
REQ-035 A shared package SHALL hold the state encoding, MAX_LEN, CNT_W and the default pattern/length constants.
REQ-036 The history shift register, fill counter and comparator SHALL be a sub-module named pattern_match_core; the FSM, config registers and counter stay in the top level.

Verification
REQ-037 Reset, start, then v_i=1 with d_i = 0,1,1,0,1 -> pattern_detect pulses on the 5th bit and match_cnt=1.
REQ-038 Default config, stream 0110101101 -> exactly 2 pulses; stream 01101101 -> exactly 1 pulse (non-overlap).
REQ-039 cfg_len=3, pattern=101, target=2, stream 101101 -> 2 pulses, then DONE with done=1; further bits are ignored.
REQ-040 cfg_we during ARMED, and cfg_we with cfg_len=0 -> cfg_err pulses once and the config is unchanged.
REQ-041 stop together with start during ARMED -> IDLE with match_cnt retained; v_i gaps mid-pattern do not break a match.
REQ-042 rst dropped after 3 of 5 pattern bits, then released and the remaining 2 bits sent -> no pulse, state IDLE.
